// File: rtl/gearbox_pkg.sv
// Shared constants and helpers for the 128<->132 gearboxes.
// Widths, cycle lengths and the 132-bit wire-order bit reverse.
package gearbox_pkg;

  localparam int GB_NIB       = 4;
  localparam int GB_W128      = 128;
  localparam int GB_W132      = 132;
  localparam int GB_CYCLE_IN  = 33;
  localparam int GB_CYCLE_OUT = 32;
  localparam int GB_RES_W     = 6;

  function automatic logic [GB_W132-1:0] gb_bitrev132(
    input logic [GB_W132-1:0] x
  );
    logic [GB_W132-1:0] r;
    for (int i = 0; i < GB_W132; i++) begin
      r[i] = x[GB_W132-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gearbox_128_132_dffr_h.sv
// dffr_h: W-bit register, async active-high reset to zero.
// Every state bit of the gearbox lives in one of these.
module dffr_h #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // plain D register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/gearbox_128_132.sv
// gearbox_128_132: packs 128-bit words into 132-bit words (33 in, 32 out).
// Optional GEARBOX_128_132_SOF_EN adds dout_sof marking each frame's first word.
module gearbox_128_132 #(
  parameter int DIN_W  = 128,
  parameter int DOUT_W = 132
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [DIN_W-1:0]  din,
  output logic              din_ready,
  input  logic              dout_ready,
  output logic              dout_valid,
  output logic [DOUT_W-1:0] dout
`ifdef GEARBOX_128_132_SOF_EN
  ,
  output logic              dout_sof
`endif
);

  import gearbox_pkg::*;

  localparam int SW = 2 * GB_W128;

  if (DIN_W != GB_W128 || DOUT_W != DIN_W + GB_NIB) begin : g_bad_width
    $error("gearbox_128_132: DIN_W must be 128, DOUT_W must be 132");
  end

  logic [SW-1:0]       storage_d, storage_q;
  logic [SW-1:0]       comb;
  logic [GB_RES_W-1:0] res_d, res_q;
  logic [DOUT_W-1:0]   dout_d, dout_q;
  logic                dout_valid_d, dout_valid_q;
  logic [7:0]          shamt;
  logic                accept;
`ifdef GEARBOX_128_132_SOF_EN
  logic                sof_d, sof_q;
`endif

  assign din_ready  = !dout_valid_q || dout_ready;
  assign accept     = din_valid && din_ready;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
`ifdef GEARBOX_128_132_SOF_EN
  assign dout_sof   = sof_q;
`endif

  // append the new word above the residue (res nibbles, wire order)
  always_comb begin
    shamt = {res_q, 2'b00};
    comb  = storage_q | ({{(SW-DIN_W){1'b0}}, din} << shamt);
  end

  // next state: res==0 only banks the word, else emit 132 bits
  always_comb begin
    storage_d    = storage_q;
    res_d        = res_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
`ifdef GEARBOX_128_132_SOF_EN
    sof_d        = sof_q;
`endif
    if (accept) begin
      if (res_q == '0) begin
        storage_d    = comb;
        res_d        = GB_RES_W'(GB_CYCLE_OUT);
        dout_valid_d = 1'b0;
      end else begin
        dout_d       = gb_bitrev132(comb[GB_W132-1:0]);
        dout_valid_d = 1'b1;
        storage_d    = comb >> GB_W132;
        res_d        = res_q - 1'b1;
`ifdef GEARBOX_128_132_SOF_EN
        sof_d        = (res_q == GB_RES_W'(GB_CYCLE_OUT));
`endif
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  dffr_h #(.W(SW)) u_storage (
    .clk(clk), .rst(rst), .d(storage_d), .q(storage_q)
  );

  dffr_h #(.W(GB_RES_W)) u_res (
    .clk(clk), .rst(rst), .d(res_d), .q(res_q)
  );

  dffr_h #(.W(DOUT_W)) u_dout (
    .clk(clk), .rst(rst), .d(dout_d), .q(dout_q)
  );

  dffr_h #(.W(1)) u_dout_valid (
    .clk(clk), .rst(rst), .d(dout_valid_d), .q(dout_valid_q)
  );

`ifdef GEARBOX_128_132_SOF_EN
  dffr_h #(.W(1)) u_sof (
    .clk(clk), .rst(rst), .d(sof_d), .q(sof_q)
  );
`endif

endmodule

// File: tb/tb_gearbox_128_132.sv
// Testbench for gearbox_128_132: directed steps plus a random soak,
// checked against a bit-queue repacking model.
module tb_gearbox_128_132;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din_valid = 1'b0;
  logic [127:0] din = '0;
  logic         din_ready;
  logic         dout_ready = 1'b0;
  logic         dout_valid;
  logic [131:0] dout;
`ifdef GEARBOX_128_132_SOF_EN
  logic         dout_sof;
`endif

  gearbox_128_132 dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid),
    .dout       (dout)
`ifdef GEARBOX_128_132_SOF_EN
    ,
    .dout_sof   (dout_sof)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // model state
  bit           bq[$];
  logic [131:0] expw[$];
  bit           exps[$];
  int           beats = 0;
  int           nacc = 0;
  int           nout = 0;
  bit           bub_pend = 0;
  bit           stall_prev = 0;
  logic [131:0] held = '0;

  task automatic chk(input string tag, input logic [131:0] obs,
                     input logic [131:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // sample away from the edge; scoreboard updates in wire-bit terms
  always @(negedge clk) begin
    logic [131:0] w;
    bit s;
    if (!rst) begin
      chk("din_ready", {131'd0, din_ready},
          {131'd0, (!dout_valid || dout_ready)});
      if (bub_pend) chk("bubble", {131'd0, dout_valid}, 132'd0);
      if (stall_prev) begin
        chk("hold_valid", {131'd0, dout_valid}, 132'd1);
        chk("hold_dout", dout, held);
      end
      if (dout_valid && dout_ready) begin
        if (expw.size() == 0) begin
          chk("extra_word", {131'd0, dout_valid}, 132'd0);
        end else begin
          w = expw.pop_front();
          s = exps.pop_front();
          chk("dout", dout, w);
`ifdef GEARBOX_128_132_SOF_EN
          chk("dout_sof", {131'd0, dout_sof}, {131'd0, s});
`endif
          nout++;
        end
      end
      bub_pend = 0;
      if (din_valid && din_ready) begin
        bub_pend = (beats % 33 == 0);
        for (int i = 0; i < 128; i++) bq.push_back(din[i]);
        if (bq.size() >= 132) begin
          for (int i = 0; i < 132; i++) w[131-i] = bq.pop_front();
          expw.push_back(w);
          exps.push_back(beats % 33 == 1);
        end
        beats++;
        nacc++;
      end
      stall_prev = dout_valid && !dout_ready;
      held = dout;
    end
  end

  task automatic clear_model();
    bq.delete();
    expw.delete();
    exps.delete();
    beats = 0;
    bub_pend = 0;
    stall_prev = 0;
  endtask

  task automatic step(input logic v, input logic [127:0] d,
                      input logic r);
    din_valid = v;
    din = d;
    dout_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    #1;
    clear_model();
    @(posedge clk);
    #1;
    chk("rst_valid", {131'd0, dout_valid}, 132'd0);
    chk("rst_dout", dout, 132'd0);
`ifdef GEARBOX_128_132_SOF_EN
    chk("rst_sof", {131'd0, dout_sof}, 132'd0);
`endif
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, a0, cyc;
    logic [131:0] h;
    logic [127:0] d;
    logic [3:0] nib;

    // reset state
    @(posedge clk);
    #1;
    do_reset();
    chk("idle_ready", {131'd0, din_ready}, 132'd1);

    // 33 all-ones beats, then one more beat must bubble
    o0 = nout;
    step(1'b1, '1, 1'b1);
    chk("ones_b1_valid", {131'd0, dout_valid}, 132'd0);
    for (int b = 2; b <= 33; b++) begin
      step(1'b1, '1, 1'b1);
      chk("ones_valid", {131'd0, dout_valid}, 132'd1);
      chk("ones_word", dout, {132{1'b1}});
    end
    step(1'b0, '0, 1'b1);
    chk("ones_count", 132'(nout - o0), 132'd32);
    step(1'b1, rnd128(), 1'b1);
    chk("ones_res0", {131'd0, dout_valid}, 132'd0);

    // first-bit placement: wire bit 0 lands on dout[131]
    do_reset();
    step(1'b1, 128'h1, 1'b1);
    step(1'b1, 128'h0, 1'b1);
    chk("first_bit", dout, 132'h8_0000_0000_0000_0000_0000_0000_0000_0000);
`ifdef GEARBOX_128_132_SOF_EN
    chk("first_sof", {131'd0, dout_sof}, 132'd1);
    step(1'b1, 128'h0, 1'b1);
    chk("second_sof", {131'd0, dout_sof}, 132'd0);
`endif

    // incrementing nibbles, 66 beats with ~30% valid gaps
    do_reset();
    o0 = nout;
    a0 = nacc;
    nib = '0;
    for (int b = 0; b < 66; b++) begin
      while ($urandom_range(0, 9) < 3) step(1'b0, rnd128(), 1'b1);
      for (int j = 0; j < 32; j++) begin
        d[4*j +: 4] = nib;
        nib = nib + 4'd1;
      end
      step(1'b1, d, 1'b1);
    end
    step(1'b0, '0, 1'b1);
    chk("nib_beats", 132'(nacc - a0), 132'd66);
    chk("nib_count", 132'(nout - o0), 132'd64);

    // backpressure: 5 stalled cycles, then same-cycle release
    do_reset();
    step(1'b1, rnd128(), 1'b1);
    step(1'b1, rnd128(), 1'b1);
    h = dout;
    for (int c = 0; c < 5; c++) begin
      din_valid = 1'b1;
      din = rnd128();
      dout_ready = 1'b0;
      #1;
      chk("bp_ready", {131'd0, din_ready}, 132'd0);
      chk("bp_valid", {131'd0, dout_valid}, 132'd1);
      chk("bp_dout", dout, h);
      @(posedge clk);
      #1;
    end
    dout_ready = 1'b1;
    #1;
    chk("bp_release", {131'd0, din_ready}, 132'd1);
    @(posedge clk);
    #1;
    for (int b = 0; b < 40; b++) step(1'b1, rnd128(), 1'b1);
    step(1'b0, '0, 1'b1);
    chk("bp_drained", 132'(expw.size()), 132'd0);

    // reset mid-cycle after beat 10, then a fresh cycle
    do_reset();
    for (int b = 0; b < 10; b++) step(1'b1, rnd128(), 1'b1);
    chk("mid_valid_pre", {131'd0, dout_valid}, 132'd1);
    rst = 1'b1;
    din_valid = 1'b0;
    #1;
    chk("async_valid", {131'd0, dout_valid}, 132'd0);
    chk("async_dout", dout, 132'd0);
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    o0 = nout;
    step(1'b1, rnd128(), 1'b1);
    chk("fresh_b1", {131'd0, dout_valid}, 132'd0);
    for (int b = 2; b <= 33; b++) step(1'b1, rnd128(), 1'b1);
    step(1'b0, '0, 1'b1);
    chk("fresh_count", 132'(nout - o0), 132'd32);

    // random soak of 10000 accepted beats
    do_reset();
    o0 = nout;
    a0 = nacc;
    cyc = 0;
    while ((nacc - a0) < 10000 && cyc < 40000) begin
      step($urandom_range(0, 9) < 7, rnd128(), $urandom_range(0, 9) < 7);
      cyc++;
    end
    chk("soak_budget", {131'd0, (cyc >= 40000)}, 132'd0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("soak_count", 132'(nout - o0), 132'((32 * (nacc - a0)) / 33));
    chk("soak_drained", 132'(expw.size()), 132'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
